// File: rtl/cam_lookup_ctrl.sv
// Request front-end for the CAM: serialises lookup/insert requests, owns the entry-valid bitmap
// and lowest-free allocation. Optional delete path enabled by `CAM_LOOKUP_CTRL_DELETE_EN.
module cam_lookup_ctrl #(
    parameter int unsigned DATA_WIDTH = 4,
    parameter int unsigned ADDR_WIDTH = 2,
    parameter int unsigned CMP_LAT    = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_op,
    input  logic [DATA_WIDTH-1:0] req_data,
`ifdef CAM_LOOKUP_CTRL_DELETE_EN
    input  logic                  req_del,
`endif
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic                  rsp_hit,
    output logic [ADDR_WIDTH-1:0] rsp_addr,
    output logic                  rsp_full,
    output logic [ADDR_WIDTH:0]   occupancy,
    output logic                  cam_write_enable,
    output logic [DATA_WIDTH-1:0] cam_din,
    output logic [ADDR_WIDTH-1:0] cam_write_addr,
    output logic [DATA_WIDTH-1:0] cam_cmp_din,
    input  logic                  cam_busy,
    input  logic                  cam_match,
    input  logic [ADDR_WIDTH-1:0] cam_match_addr
);

    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
    localparam int unsigned CNT_W = $clog2(CMP_LAT + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_CMP, S_CWAIT, S_EVAL, S_WR, S_SETTLE, S_RESP
    } state_t;

    state_t                state_q, state_d;
    logic                  op_q, op_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [DEPTH-1:0]      valid_q, valid_d;
    logic [ADDR_WIDTH:0]   occ_q, occ_d;
    logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic                  rsp_hit_q, rsp_hit_d;
    logic [ADDR_WIDTH-1:0] rsp_addr_q, rsp_addr_d;
    logic                  rsp_full_q, rsp_full_d;
`ifdef CAM_LOOKUP_CTRL_DELETE_EN
    logic                  del_q, del_d;
`endif

    logic                  wr_fire;
    logic                  hit;
    logic                  table_full;
    logic [ADDR_WIDTH-1:0] free_addr;
    logic                  free_found;

    // A CAM match only counts if the controller still considers that entry live.
    assign hit        = cam_match && valid_q[cam_match_addr];
    assign table_full = (occ_q == (ADDR_WIDTH+1)'(DEPTH));

    always_comb begin
        free_addr  = '0;
        free_found = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (!valid_q[i] && !free_found) begin
                free_addr  = ADDR_WIDTH'(i);
                free_found = 1'b1;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        data_d     = data_q;
        cnt_d      = cnt_q;
        valid_d    = valid_q;
        occ_d      = occ_q;
        wr_addr_d  = wr_addr_q;
        rsp_hit_d  = rsp_hit_q;
        rsp_addr_d = rsp_addr_q;
        rsp_full_d = rsp_full_q;
        wr_fire    = 1'b0;
`ifdef CAM_LOOKUP_CTRL_DELETE_EN
        del_d      = del_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    op_d    = req_op;
                    data_d  = req_data;
`ifdef CAM_LOOKUP_CTRL_DELETE_EN
                    del_d   = req_del;
`endif
                    state_d = S_CMP;
                end
            end
            S_CMP: begin
                if (!cam_busy) begin
                    cnt_d   = '0;
                    state_d = S_CWAIT;
                end
            end
            S_CWAIT: begin
                if (cnt_q == CNT_W'(CMP_LAT - 1)) state_d = S_EVAL;
                else                              cnt_d   = cnt_q + CNT_W'(1);
            end
            S_EVAL: begin
                rsp_hit_d  = 1'b0;
                rsp_addr_d = '0;
                rsp_full_d = 1'b0;
                state_d    = S_RESP;
`ifdef CAM_LOOKUP_CTRL_DELETE_EN
                if (del_q) begin
                    if (hit) begin
                        valid_d[cam_match_addr] = 1'b0;
                        occ_d                   = occ_q - (ADDR_WIDTH+1)'(1);
                        rsp_hit_d               = 1'b1;
                        rsp_addr_d              = cam_match_addr;
                    end
                end else
`endif
                if (!op_q || hit) begin
                    rsp_hit_d  = hit;
                    rsp_addr_d = hit ? cam_match_addr : '0;
                end else if (!table_full) begin
                    wr_addr_d  = free_addr;
                    rsp_addr_d = free_addr;
                    state_d    = S_WR;
                end else begin
                    rsp_full_d = 1'b1;
                end
            end
            S_WR: begin
                if (!cam_busy) begin
                    wr_fire            = 1'b1;
                    valid_d[wr_addr_q] = 1'b1;
                    occ_d              = occ_q + (ADDR_WIDTH+1)'(1);
                    state_d            = S_SETTLE;
                end
            end
            S_SETTLE: state_d = S_RESP;
            S_RESP: begin
                if (rsp_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            op_q       <= 1'b0;
            data_q     <= '0;
            cnt_q      <= '0;
            valid_q    <= '0;
            occ_q      <= '0;
            wr_addr_q  <= '0;
            rsp_hit_q  <= 1'b0;
            rsp_addr_q <= '0;
            rsp_full_q <= 1'b0;
`ifdef CAM_LOOKUP_CTRL_DELETE_EN
            del_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            data_q     <= data_d;
            cnt_q      <= cnt_d;
            valid_q    <= valid_d;
            occ_q      <= occ_d;
            wr_addr_q  <= wr_addr_d;
            rsp_hit_q  <= rsp_hit_d;
            rsp_addr_q <= rsp_addr_d;
            rsp_full_q <= rsp_full_d;
`ifdef CAM_LOOKUP_CTRL_DELETE_EN
            del_q      <= del_d;
`endif
        end
    end

    // Handshake strobes are masked by rst so nothing is offered or written while reset is held.
    assign req_ready        = (state_q == S_IDLE) && !rst;
    assign rsp_valid        = (state_q == S_RESP) && !rst;
    assign cam_write_enable = wr_fire && !rst;
    assign rsp_hit          = rsp_hit_q;
    assign rsp_addr         = rsp_addr_q;
    assign rsp_full         = rsp_full_q;
    assign occupancy        = occ_q;
    assign cam_din          = data_q;
    assign cam_cmp_din      = data_q;
    assign cam_write_addr   = wr_addr_q;

endmodule

// File: tb/tb_cam_lookup_ctrl.sv
// Scoreboard bench for cam_lookup_ctrl with a behavioural CAM (CMP_LAT=1).
// Delete scenarios run when CAM_LOOKUP_CTRL_DELETE_EN is defined.
module tb_cam_lookup_ctrl;
    localparam int DW = 4;
    localparam int AW = 2;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_op = 1'b0;
    logic [DW-1:0] req_data = '0;
`ifdef CAM_LOOKUP_CTRL_DELETE_EN
    logic          req_del = 1'b0;
`endif
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic          rsp_hit;
    logic [AW-1:0] rsp_addr;
    logic          rsp_full;
    logic [AW:0]   occupancy;
    logic          cam_write_enable;
    logic [DW-1:0] cam_din;
    logic [AW-1:0] cam_write_addr;
    logic [DW-1:0] cam_cmp_din;
    logic          cam_busy = 1'b0;
    logic          cam_match = 1'b0;
    logic [AW-1:0] cam_match_addr = '0;

    cam_lookup_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CMP_LAT(1)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_data(req_data),
`ifdef CAM_LOOKUP_CTRL_DELETE_EN
        .req_del(req_del),
`endif
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_hit(rsp_hit), .rsp_addr(rsp_addr),
        .rsp_full(rsp_full), .occupancy(occupancy),
        .cam_write_enable(cam_write_enable), .cam_din(cam_din), .cam_write_addr(cam_write_addr),
        .cam_cmp_din(cam_cmp_din), .cam_busy(cam_busy), .cam_match(cam_match),
        .cam_match_addr(cam_match_addr)
    );

    // Behavioural CAM: one-cycle compare, lowest matching written entry wins; it knows nothing of validity.
    logic [DW-1:0]    mem [DEPTH];
    logic [DEPTH-1:0] used = '0;
    always @(posedge clk) begin
        if (cam_write_enable) begin
            mem[cam_write_addr]  <= cam_din;
            used[cam_write_addr] <= 1'b1;
        end
        if (!cam_busy) begin
            cam_match      <= 1'b0;
            cam_match_addr <= '0;
            for (int i = DEPTH - 1; i >= 0; i--) begin
                if (used[i] && mem[i] == cam_cmp_din) begin
                    cam_match      <= 1'b1;
                    cam_match_addr <= AW'(i);
                end
            end
        end
    end

    typedef struct {
        string         name;
        logic          hit;
        logic [AW-1:0] addr;
        logic          full;
        int            lat;
        int            hold;
    } exp_t;
    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] din;
    } wr_t;

    exp_t rq[$];
    wr_t  wq[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   accept_cyc = 0;
    int   done = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Response monitor / consumer: withholds rsp_ready for the expected hold count, then pops and compares.
    initial begin : rsp_mon
        bit            seen;
        bit            have_e;
        int            hold;
        int            lat;
        exp_t          e;
        logic          s_hit;
        logic [AW-1:0] s_addr;
        logic          s_full;
        seen = 0; have_e = 0; hold = 0; lat = 0;
        forever begin
            @(negedge clk);
            if (rsp_valid) begin
                if (!seen) begin
                    seen   = 1;
                    lat    = cyc - accept_cyc;
                    s_hit  = rsp_hit;
                    s_addr = rsp_addr;
                    s_full = rsp_full;
                    if (rq.size() == 0) begin
                        checks++;
                        failures++;
                        have_e = 0;
                        hold   = 0;
                        $display("FAIL unexpected_rsp: got hit=%0d addr=%0d full=%0d expected no response",
                                 rsp_hit, rsp_addr, rsp_full);
                    end else begin
                        e      = rq.pop_front();
                        have_e = 1;
                        hold   = e.hold;
                    end
                end else begin
                    chk({e.name, "_stable_hit"}, 32'(rsp_hit), 32'(s_hit));
                    chk({e.name, "_stable_addr"}, 32'(rsp_addr), 32'(s_addr));
                    chk({e.name, "_stable_full"}, 32'(rsp_full), 32'(s_full));
                    chk({e.name, "_req_ready_low"}, 32'(req_ready), 32'(0));
                end
                if (hold == 0) begin
                    rsp_ready = 1'b1;
                    if (have_e) begin
                        chk({e.name, "_hit"}, 32'(rsp_hit), 32'(e.hit));
                        chk({e.name, "_addr"}, 32'(rsp_addr), 32'(e.addr));
                        chk({e.name, "_full"}, 32'(rsp_full), 32'(e.full));
                        if (e.lat > 0) chk({e.name, "_latency"}, 32'(lat), 32'(e.lat));
                    end
                    seen = 0;
                    done++;
                end else begin
                    hold--;
                    rsp_ready = 1'b0;
                end
            end else begin
                rsp_ready = 1'b0;
            end
        end
    end

    wr_t wcur;
    always @(negedge clk) begin
        if (cam_write_enable) begin
            if (wq.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_write: got addr=%0d din=%0d expected no write", cam_write_addr, cam_din);
            end else begin
                wcur = wq.pop_front();
                chk("write_addr", 32'(cam_write_addr), 32'(wcur.addr));
                chk("write_din", 32'(cam_din), 32'(wcur.din));
            end
        end
    end

    task automatic issue(input logic op, input logic [DW-1:0] d, input logic del);
        int t;
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = op;
        req_data  = d;
`ifdef CAM_LOOKUP_CTRL_DELETE_EN
        req_del   = del;
`else
        if (del) $display("delete requested in a build without delete support");
`endif
        t = 0;
        while (!req_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (!req_ready) begin
            chk("req_ready_timeout", 32'(req_ready), 32'(1));
            req_valid = 1'b0;
            return;
        end
        accept_cyc = cyc + 1;
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic wait_done(input string name, input int target);
        int t;
        t = 0;
        while (done < target && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (done < target) chk({name, "_rsp_timeout"}, 32'(done), 32'(target));
    endtask

    task automatic txn(input string name, input logic op, input logic [DW-1:0] d, input logic del,
                       input logic hit, input logic [AW-1:0] addr, input logic full, input int lat,
                       input bit wr, input logic [AW-1:0] waddr);
        int target;
        exp_t e;
        wr_t  w;
        target = done + 1;
        e.name = name; e.hit = hit; e.addr = addr; e.full = full; e.lat = lat; e.hold = 0;
        rq.push_back(e);
        if (wr) begin
            w.addr = waddr;
            w.din  = d;
            wq.push_back(w);
        end
        issue(op, d, del);
        wait_done(name, target);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_req_ready", 32'(req_ready), 32'(0));
        chk("rst_rsp_valid", 32'(rsp_valid), 32'(0));
        chk("rst_write_en", 32'(cam_write_enable), 32'(0));
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("post_rst_req_ready", 32'(req_ready), 32'(1));
        chk("post_rst_occupancy", 32'(occupancy), 32'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int   target;
        exp_t e;
        do_reset();

        txn("lookup4",   1'b0, 4'd4, 1'b0, 1'b0, 2'd0, 1'b0, 3, 1'b0, 2'd0);
        txn("insert9",   1'b1, 4'd9, 1'b0, 1'b0, 2'd0, 1'b0, 5, 1'b1, 2'd0);
        chk("occ_after_insert9", 32'(occupancy), 32'(1));
        txn("lookup9",   1'b0, 4'd9, 1'b0, 1'b1, 2'd0, 1'b0, 3, 1'b0, 2'd0);
        txn("insert9_dup", 1'b1, 4'd9, 1'b0, 1'b1, 2'd0, 1'b0, 3, 1'b0, 2'd0);
        chk("occ_after_dup", 32'(occupancy), 32'(1));
        txn("insert1",   1'b1, 4'd1, 1'b0, 1'b0, 2'd1, 1'b0, 5, 1'b1, 2'd1);
        txn("insert2",   1'b1, 4'd2, 1'b0, 1'b0, 2'd2, 1'b0, 5, 1'b1, 2'd2);
        txn("insert3",   1'b1, 4'd3, 1'b0, 1'b0, 2'd3, 1'b0, 5, 1'b1, 2'd3);
        chk("occ_full", 32'(occupancy), 32'(4));
        txn("insert5_full", 1'b1, 4'd5, 1'b0, 1'b0, 2'd0, 1'b1, 3, 1'b0, 2'd0);
        chk("occ_after_full", 32'(occupancy), 32'(4));

        // Busy for 5 compare cycles, then response held for 4 cycles of backpressure.
        target = done + 1;
        e.name = "busy_lookup2"; e.hit = 1'b1; e.addr = 2'd2; e.full = 1'b0; e.lat = 8; e.hold = 4;
        rq.push_back(e);
        cam_busy = 1'b1;
        issue(1'b0, 4'd2, 1'b0);
        repeat (6) @(negedge clk);
        cam_busy = 1'b0;
        wait_done("busy_lookup2", target);

`ifdef CAM_LOOKUP_CTRL_DELETE_EN
        txn("delete1",   1'b0, 4'd1, 1'b1, 1'b1, 2'd1, 1'b0, 3, 1'b0, 2'd0);
        chk("occ_after_delete", 32'(occupancy), 32'(3));
        txn("lookup1_deleted", 1'b0, 4'd1, 1'b0, 1'b0, 2'd0, 1'b0, 3, 1'b0, 2'd0);
        txn("delete8_miss", 1'b0, 4'd8, 1'b1, 1'b0, 2'd0, 1'b0, 3, 1'b0, 2'd0);
        txn("insert7_reuse", 1'b1, 4'd7, 1'b0, 1'b0, 2'd1, 1'b0, 5, 1'b1, 2'd1);
        chk("occ_after_reuse", 32'(occupancy), 32'(4));
`endif

        do_reset();
        // Insert miss stalled in WR by cam_busy, then reset: the request is dropped silently.
        issue(1'b1, 4'd6, 1'b0);
        repeat (3) @(negedge clk);
        cam_busy = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("wr_rst_write_en", 32'(cam_write_enable), 32'(0));
        @(negedge clk);
        rst = 1'b0;
        cam_busy = 1'b0;
        #1;
        chk("wr_rst_occupancy", 32'(occupancy), 32'(0));
        chk("wr_rst_req_ready", 32'(req_ready), 32'(1));
        repeat (3) @(negedge clk);
        txn("lookup9_after_rst", 1'b0, 4'd9, 1'b0, 1'b0, 2'd0, 1'b0, 3, 1'b0, 2'd0);
        chk("occ_final", 32'(occupancy), 32'(0));

        repeat (5) @(negedge clk);
        chk("pending_writes", 32'(wq.size()), 32'(0));
        chk("pending_rsps", 32'(rq.size()), 32'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/cam_lookup_ctrl.md
# cam_lookup_ctrl

- Request front-end sitting directly upstream of the `cam` block. Accepts lookup and insert requests over a valid/ready handshake and drives the CAM's write and compare ports.
- Owns the entry-valid bitmap and lowest-free-slot allocation.
- Suppresses duplicate inserts by searching before writing.
- Returns hit, address and table-full status on a valid/ready response channel.

## Interface
Parameters:
- `DATA_WIDTH`, 4, key width; matches the CAM's `DATA_WIDTH`.
- `ADDR_WIDTH`, 2, CAM address width; the table holds 2**`ADDR_WIDTH` entries.
- `CMP_LAT`, 1, cycles from driving `cam_cmp_din` to a valid `cam_match`/`cam_match_addr`; legal range is 1 or more.

Ports:
- `clk`  in  1  single clock.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  controller can accept a request.
- `req_op`  in  1  0 = lookup, 1 = insert.
- `req_data`  in  `DATA_WIDTH`  key.
- `rsp_valid`  out  1  response present.
- `rsp_ready`  in  1  consumer takes the response.
- `rsp_hit`  out  1  key found in a valid entry.
- `rsp_addr`  out  `ADDR_WIDTH`  address of the hit or of the newly written entry.
- `rsp_full`  out  1  insert rejected because the table is full.
- `occupancy`  out  `ADDR_WIDTH`+1  count of valid entries.
- `cam_write_enable`  out  1  one-cycle write strobe to the CAM.
- `cam_din`  out  `DATA_WIDTH`  write data.
- `cam_write_addr`  out  `ADDR_WIDTH`  write address.
- `cam_cmp_din`  out  `DATA_WIDTH`  compare key.
- `cam_busy`  in  1  CAM is busy; no compare or write may be issued while high.
- `cam_match`  in  1  CAM match flag.
- `cam_match_addr`  in  `ADDR_WIDTH`  CAM match address.

## Operation
- The request is accepted on `req_valid && req_ready`. `req_op` and `req_data` are latched into a request register.
- `cam_din` and `cam_cmp_din` are driven from the request register.
- States:
  - IDLE: `req_ready`=1. On accept go to CMP.
  - CMP: wait for `cam_busy`=0, then go to CWAIT. The CAM samples `cam_cmp_din` in the cycle `cam_busy` is low.
  - CWAIT: count `CMP_LAT` cycles, then go to EVAL.
  - EVAL: compute hit = `cam_match` && valid[`cam_match_addr`]. A match on an invalid entry is a miss.
    - Lookup: go to RESP.
    - Insert with hit: go to RESP with the existing address; no write.
    - Insert with miss and `occupancy` < 2**`ADDR_WIDTH`: go to WR.
    - Insert with miss and table full: go to RESP with `rsp_full`=1, `rsp_addr`=0.
  - WR: wait for `cam_busy`=0. Then pulse `cam_write_enable` for exactly one cycle, with `cam_write_addr` = lowest-index invalid entry. In the same edge, set that valid bit, increment `occupancy`, and go to SETTLE.
  - SETTLE: hold one cycle so the CAM can raise `cam_busy`, then go to RESP.
  - RESP: `rsp_valid`=1. Outputs are held stable until `rsp_ready`, then go to IDLE.
- An insert miss reports `rsp_hit`=0 and `rsp_addr` = the written address.
- `rsp_full` is only ever set on an insert response.
- `occupancy` never exceeds 2**`ADDR_WIDTH`.

## Timing
- Reset values:
  - All outputs are 0, including `req_ready` while `rst` is high.
  - Valid bitmap cleared, `occupancy`=0, state IDLE.
  - `req_ready`=1 on the first cycle after `rst` falls.
- Lookup latency with `cam_busy` low: handshake at edge N, `rsp_valid` high from edge N+2+`CMP_LAT`. With `CMP_LAT`=1 this is 3 cycles.
- Insert-miss latency: lookup latency + 2 cycles (WR and SETTLE) when `cam_busy` is low.
- `cam_busy` high stalls CMP and WR indefinitely. Nothing is issued while it is high.
- Response backpressure: `req_ready` stays 0 until the response is consumed. Only one request is in flight at a time.
- `rst` during any state: the next edge returns to IDLE, clears the bitmap and `occupancy`, and deasserts `cam_write_enable` and `rsp_valid`. The pending request is dropped with no response.
- `req_valid` outside IDLE is ignored; the requester must hold it.

## Configuration
- Macro: `CAM_LOOKUP_CTRL_DELETE_EN`.
- Defined:
  - Adds input `req_del` (1 bit), sampled on accept, which overrides `req_op`.
  - A delete runs CMP → CWAIT → EVAL. On a hit it clears valid[`cam_match_addr`], decrements `occupancy`, and responds with `rsp_hit`=1 and that address. On a miss it responds with `rsp_hit`=0.
  - Deletes never write the CAM.
  - The freed slot is reused by the lowest-free allocation.
- Undefined: no `req_del` port and no deletion path. Entries are cleared only by `rst`.

## Test plan
- After reset, lookup 4 → `rsp_hit`=0, `rsp_valid` exactly 3 cycles after handshake, no `cam_write_enable`.
- Insert 9 → `cam_write_enable` pulse with `cam_write_addr`=0 and `cam_din`=9, response hit=0 addr=0, `occupancy`=1. Then lookup 9 → hit=1, addr=0.
- Insert 9 again → hit=1, addr=0, no write pulse, `occupancy` stays 1.
- Insert 1, 2, 3, then insert 5 → writes to addresses 1, 2, 3; the fifth insert responds with `rsp_full`=1, hit=0, no write, `occupancy`=4.
- Hold `cam_busy` high for 5 cycles after accepting a lookup → `cam_cmp_din` is not consumed and no response is issued until `cam_busy` drops. Then hold `rsp_ready` low for 4 cycles → response fields are held stable and `req_ready`=0 throughout.
- With `CAM_LOOKUP_CTRL_DELETE_EN`: table {9,1,2,3}, delete 1 → hit=1, addr=1, `occupancy`=3. Then insert 7 → written to addr 1.
- Assert `rst` during WR → no write pulse after reset, `occupancy`=0, and a lookup of 9 misses.
